tb_tcdm_banked_mem: RTL and testbench

//  Parametrised multi-port, word-interleaved TCDM memory model for the HWPE bench.

---
 rtl/tb_tcdm_banked_mem_if.sv | 31 +++
 rtl/tb_tcdm_banked_mem.sv | 203 ++++++++++++++++++++
 tb/tb_tb_tcdm_banked_mem.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tb_tcdm_banked_mem_if.sv
// ============================================================================
// Module      : tb_tcdm_banked_mem_if
// Description : Bundle of N_PORTS TCDM request/response channels (req/gnt + r_valid).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tb_tcdm_banked_mem_if #(
    parameter int N_PORTS = 4
);
    logic [N_PORTS-1:0]       req;
    logic [N_PORTS-1:0][31:0] add;
    logic [N_PORTS-1:0]       wen;
    logic [N_PORTS-1:0][3:0]  be;
    logic [N_PORTS-1:0][31:0] data;
    logic [N_PORTS-1:0]       gnt;
    logic [N_PORTS-1:0][31:0] r_data;
    logic [N_PORTS-1:0]       r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

`default_nettype wire

// File: rtl/tb_tcdm_banked_mem.sv
// ============================================================================
// Module      : tb_tcdm_banked_mem
// Description : Multi-port word-interleaved TCDM model, per-bank round-robin
//               arbitration, optional LFSR stall injection (TCDM_STALL_INJECT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcdm_banked_mem #(
    parameter int          N_PORTS      = 4,
    parameter int          N_BANKS      = 4,
    parameter int          MEM_BYTES    = 256*1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [7:0]  STALL_THRESH = 8'd26,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [31:0] ERR_RDATA    = 32'hDEADBEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      stall_en_i,
    tb_tcdm_banked_mem_if.slave       tcdm,
    output logic [N_PORTS-1:0][31:0]  cnt_rd,
    output logic [N_PORTS-1:0][31:0]  cnt_wr,
    output logic [31:0]               cnt_err
);

    localparam int          c_words     = MEM_BYTES / 4;
    localparam int          c_aw        = $clog2(c_words);
    localparam int          c_bw        = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int          c_pw        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [31:0] c_mem_bytes = 32'(MEM_BYTES);
    localparam logic [c_pw:0] c_np      = (c_pw+1)'(N_PORTS);

    // Flat word array; index = word, so hierarchical preloads work on 'memory'.
    logic [31:0] memory [c_words];

    logic [N_PORTS-1:0][31:0]      w_off;
    logic [N_PORTS-1:0]            w_inr;
    logic [N_PORTS-1:0][c_aw-1:0]  w_word;
    logic [N_PORTS-1:0][c_bw-1:0]  w_bank;
    logic [N_PORTS-1:0]            w_stall;
    logic [N_BANKS-1:0][N_PORTS-1:0] w_elig;
    logic [N_BANKS-1:0]            w_any;
    logic [N_BANKS-1:0][c_pw-1:0]  w_win;
    logic [c_pw:0]                 w_idx;
    logic [N_PORTS-1:0]            w_gnt;
    logic                          w_err_gnt;

    logic [N_BANKS-1:0][c_pw-1:0]  r_rr;
    logic [N_PORTS-1:0]            r_valid;
    logic [N_PORTS-1:0][31:0]      r_rdata;
    logic [N_PORTS-1:0][31:0]      r_cnt_rd;
    logic [N_PORTS-1:0][31:0]      r_cnt_wr;
    logic [31:0]                   r_cnt_err;

    // Address decode; out-of-range accesses compete for bank 0.
    always_comb begin
        w_off  = '0;
        w_inr  = '0;
        w_word = '0;
        w_bank = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_off[p]  = tcdm.add[p] - BASE_ADDR;
            w_inr[p]  = (tcdm.add[p] >= BASE_ADDR) && (w_off[p] < c_mem_bytes);
            w_word[p] = w_off[p][c_aw+1:2];
            if (w_inr[p] && (N_BANKS > 1)) begin
                w_bank[p] = w_word[p][c_bw-1:0];
            end
        end
    end

`ifdef TCDM_STALL_INJECT_EN
    logic [N_PORTS-1:0][15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (rst_i) begin
                r_lfsr[p] <= LFSR_SEED ^ 16'(p + 1);
            end else begin
                r_lfsr[p] <= {r_lfsr[p][14:0],
                              r_lfsr[p][15] ^ r_lfsr[p][13] ^ r_lfsr[p][12] ^ r_lfsr[p][10]};
            end
        end
    end

    always_comb begin
        w_stall = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_stall[p] = stall_en_i && (r_lfsr[p][7:0] < STALL_THRESH);
        end
    end
`else
    logic [16:0] w_unused_cfg;
    assign w_unused_cfg = {stall_en_i, LFSR_SEED ^ {8'h00, STALL_THRESH}};
    assign w_stall      = '0;
`endif

    always_comb begin
        w_elig = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_elig[b][p] = tcdm.req[p] && !w_stall[p] && !rst_i &&
                               (w_bank[p] == c_bw'(b));
            end
        end
    end

    // Round-robin: first eligible port at or after rr[b], wrapping.
    always_comb begin
        w_gnt = '0;
        w_any = '0;
        w_win = '0;
        w_idx = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int k = 0; k < N_PORTS; k++) begin
                w_idx = {1'b0, r_rr[b]} + (c_pw+1)'(k);
                if (w_idx >= c_np) begin
                    w_idx = w_idx - c_np;
                end
                if (!w_any[b] && w_elig[b][w_idx[c_pw-1:0]]) begin
                    w_any[b]                 = 1'b1;
                    w_win[b]                 = w_idx[c_pw-1:0];
                    w_gnt[w_idx[c_pw-1:0]]   = 1'b1;
                end
            end
        end
    end

    assign w_err_gnt = |(w_gnt & ~w_inr);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_rr <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (w_any[b]) begin
                    r_rr[b] <= (w_win[b] == c_pw'(N_PORTS - 1)) ? '0 : w_win[b] + c_pw'(1);
                end
            end
        end
    end

    // Memory has no reset so preloaded contents survive rst_i.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_gnt[p] && !tcdm.wen[p] && w_inr[p]) begin
                for (int i = 0; i < 4; i++) begin
                    if (tcdm.be[p][i]) begin
                        memory[w_word[p]][8*i +: 8] <= tcdm.data[p][8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_rdata <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_valid[p] <= w_gnt[p];
                if (w_gnt[p] && tcdm.wen[p]) begin
                    r_rdata[p] <= w_inr[p] ? memory[w_word[p]] : ERR_RDATA;
                end else begin
                    r_rdata[p] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_cnt_rd  <= '0;
            r_cnt_wr  <= '0;
            r_cnt_err <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_gnt[p] && tcdm.wen[p] && (r_cnt_rd[p] != '1)) begin
                    r_cnt_rd[p] <= r_cnt_rd[p] + 32'd1;
                end
                if (w_gnt[p] && !tcdm.wen[p] && (r_cnt_wr[p] != '1)) begin
                    r_cnt_wr[p] <= r_cnt_wr[p] + 32'd1;
                end
            end
            if (w_err_gnt && (r_cnt_err != '1)) begin
                r_cnt_err <= r_cnt_err + 32'd1;
            end
        end
    end

    // A response still in flight when reset arrives is suppressed immediately.
    assign tcdm.gnt     = w_gnt;
    assign tcdm.r_valid = rst_i ? '0 : r_valid;
    assign tcdm.r_data  = rst_i ? '0 : r_rdata;
    assign cnt_rd       = r_cnt_rd;
    assign cnt_wr       = r_cnt_wr;
    assign cnt_err      = r_cnt_err;

endmodule

`default_nettype wire

// File: tb/tb_tb_tcdm_banked_mem.sv
// ============================================================================
// Module      : tb_tb_tcdm_banked_mem
// Description : Scoreboard bench for tb_tcdm_banked_mem (4 ports, 4 banks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_tcdm_banked_mem;

    localparam int NP = 4;
    localparam int MB = 256*1024;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic stall_en;
    logic [NP-1:0][31:0] cnt_rd;
    logic [NP-1:0][31:0] cnt_wr;
    logic [31:0]         cnt_err;

    tb_tcdm_banked_mem_if #(.N_PORTS(NP)) tcdm ();

    tb_tcdm_banked_mem #(
        .N_PORTS      (NP),
        .N_BANKS      (4),
        .MEM_BYTES    (MB),
        .BASE_ADDR    (32'h0),
        .STALL_THRESH (8'd128),
        .LFSR_SEED    (16'hACE1),
        .ERR_RDATA    (32'hDEADBEEF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .stall_en_i (stall_en),
        .tcdm       (tcdm.slave),
        .cnt_rd     (cnt_rd),
        .cnt_wr     (cnt_wr),
        .cnt_err    (cnt_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mm [int];
    logic [31:0] sbq [NP][$];
    logic [31:0] e_rd [NP];
    logic [31:0] e_wr [NP];
    logic [31:0] e_err;

    logic [NP-1:0]       s_req;
    logic [NP-1:0]       s_wen;
    logic [NP-1:0][31:0] s_add;
    logic [NP-1:0][31:0] s_dat;
    logic [NP-1:0][3:0]  s_be;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_req = '0; s_wen = '1; s_add = '0; s_dat = '0; s_be = '0;
    endtask

    task automatic set_rd(input int p, input logic [31:0] a);
        s_req[p] = 1'b1; s_wen[p] = 1'b1; s_add[p] = a; s_dat[p] = '0; s_be[p] = 4'h0;
    endtask

    task automatic set_wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        s_req[p] = 1'b1; s_wen[p] = 1'b0; s_add[p] = a; s_dat[p] = d; s_be[p] = be;
    endtask

    // One clock cycle: drive, check responses due, check/score grants, advance.
    task automatic cyc(input logic [NP-1:0] exp_gnt, input bit do_rst, input bit do_clr,
                       input bit chk_gnt, output logic [NP-1:0] got);
        logic [NP-1:0] g;
        logic [31:0]   e;
        logic [31:0]   w;
        bit            due;
        bit            oor;
        rst = do_rst; clear = do_clr;
        tcdm.req = s_req; tcdm.wen = s_wen; tcdm.add = s_add; tcdm.data = s_dat; tcdm.be = s_be;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            due = (sbq[p].size() != 0) && !do_rst;
            check_val($sformatf("rvalid%0d", p), 32'(tcdm.r_valid[p]), 32'(due));
            if (sbq[p].size() != 0) begin
                e = sbq[p].pop_front();
                if (due && tcdm.r_valid[p]) check_val($sformatf("rdata%0d", p), tcdm.r_data[p], e);
            end
        end
        got = tcdm.gnt;
        if (chk_gnt) check_val("gnt", 32'(tcdm.gnt), 32'(exp_gnt));
        g = chk_gnt ? exp_gnt : tcdm.gnt;
        for (int p = 0; p < NP; p++) begin
            if (g[p]) begin
                oor = (s_add[p] >= 32'(MB));
                w   = s_add[p] >> 2;
                if (s_wen[p]) begin
                    sbq[p].push_back(oor ? 32'hDEADBEEF : mm[int'(w)]);
                    e_rd[p] = e_rd[p] + 1;
                end else begin
                    sbq[p].push_back(32'h0);
                    e_wr[p] = e_wr[p] + 1;
                    if (!oor) begin
                        e = mm.exists(int'(w)) ? mm[int'(w)] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (s_be[p][i]) e[8*i +: 8] = s_dat[p][8*i +: 8];
                        mm[int'(w)] = e;
                    end
                end
                if (oor) e_err = e_err + 1;
            end
        end
        if (do_rst || do_clr) begin
            for (int p = 0; p < NP; p++) begin e_rd[p] = 0; e_wr[p] = 0; end
            e_err = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt();
        for (int p = 0; p < NP; p++) begin
            check_val($sformatf("cnt_rd%0d", p), cnt_rd[p], e_rd[p]);
            check_val($sformatf("cnt_wr%0d", p), cnt_wr[p], e_wr[p]);
        end
        check_val("cnt_err", cnt_err, e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0] g;
        int            n;
        for (int p = 0; p < NP; p++) begin e_rd[p] = 0; e_wr[p] = 0; end
        e_err = 0; stall_en = 1'b0;
        idle();
        repeat (3) cyc('0, 1, 0, 1, g);
        chk_cnt();

        // Preload word 5, then read it back
        set_wr(0, 32'h14, 32'h1234_5678, 4'hF); cyc(4'b0001, 0, 0, 1, g);
        idle(); set_rd(0, 32'h14);             cyc(4'b0001, 0, 0, 1, g);
        idle();                                cyc('0, 0, 0, 1, g);
        check_val("t1_cnt_rd0", cnt_rd[0], 32'd1);
        chk_cnt();

        // Byte-enable write, back-to-back grants
        idle(); set_wr(1, 32'h20, 32'h0, 4'hF);          cyc(4'b0010, 0, 0, 1, g);
        idle(); set_wr(1, 32'h20, 32'hAABB_CCDD, 4'h5);  cyc(4'b0010, 0, 0, 1, g);
        idle(); set_rd(1, 32'h20);                       cyc(4'b0010, 0, 0, 1, g);
        idle();                                          cyc('0, 0, 0, 1, g);
        check_val("t2_model", mm[8], 32'h00BB_00DD);

        // Four banks in parallel
        idle();
        for (int p = 0; p < NP; p++) set_wr(p, 32'(4*p), 32'h1000_0000 + 32'(p) * 32'h0101, 4'hF);
        cyc(4'b1111, 0, 0, 1, g);
        idle();
        for (int p = 0; p < NP; p++) set_rd(p, 32'(4*p));
        cyc(4'b1111, 0, 0, 1, g);
        idle(); chk_cnt();
        set_rd(0, 32'h0); cyc(4'b0001, 0, 1, 1, g);
        idle(); cyc('0, 0, 0, 1, g);
        chk_cnt();

        // Same bank, all four ports: round-robin order 0,1,2,3
        for (int p = 0; p < NP; p++) set_rd(p, 32'h0);
        cyc(4'b0001, 0, 0, 1, g);
        cyc(4'b0010, 0, 0, 1, g);
        cyc(4'b0100, 0, 0, 1, g);
        cyc(4'b1000, 0, 0, 1, g);
        idle(); cyc('0, 0, 0, 1, g);
        chk_cnt();

        // Out-of-range read and write
        set_rd(2, 32'(MB));                     cyc(4'b0100, 0, 0, 1, g);
        check_val("t4_err1", cnt_err, 32'd1);
        idle(); set_wr(2, 32'(MB), 32'hFFFF_FFFF, 4'hF); cyc(4'b0100, 0, 0, 1, g);
        idle(); set_rd(2, 32'h0);               cyc(4'b0100, 0, 0, 1, g);
        idle();                                 cyc('0, 0, 0, 1, g);
        check_val("t4_err2", cnt_err, 32'd2);
        chk_cnt();
        set_rd(0, 32'h0); set_rd(1, 32'(MB));   cyc(4'b0001, 0, 0, 1, g);
        s_req[0] = 1'b0;                        cyc(4'b0010, 0, 0, 1, g);
        idle();                                 cyc('0, 0, 0, 1, g);
        chk_cnt();

        // Reset right after a read grant drops the response
        set_rd(0, 32'h14); cyc(4'b0001, 0, 0, 1, g);
        idle(); set_rd(2, 32'h0); cyc('0, 1, 0, 1, g);
        idle(); cyc('0, 1, 0, 1, g);
        chk_cnt();
        set_rd(0, 32'h14); cyc(4'b0001, 0, 0, 1, g);
        idle(); cyc('0, 0, 0, 1, g);
        check_val("t5_preload", mm[5], 32'h1234_5678);

`ifdef TCDM_STALL_INJECT_EN
        stall_en = 1'b1; n = 0;
        set_rd(0, 32'h0);
        for (int i = 0; i < 1000; i++) begin
            cyc('0, 0, 0, 0, g);
            n += int'(g[0]);
        end
        check_val("stall_rate", 32'(n >= 400 && n <= 600), 32'd1);
        stall_en = 1'b0;
`else
        n = 0;
        stall_en = 1'b1;
`endif
        set_rd(0, 32'h0);
        repeat (20) cyc(4'b0001, 0, 0, 1, g);
        idle(); cyc('0, 0, 0, 1, g);
        stall_en = 1'b0;
        chk_cnt();

        for (int p = 0; p < NP; p++) check_val($sformatf("q_empty%0d", p), 32'(sbq[p].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
